// File: rtl/d_ff_pkg.sv
// Shared constants and the parameter check used by the d_ff_stage pipeline.
package d_ff_pkg;

  localparam int unsigned D_FF_WIDTH_DEF  = 1;
  localparam int unsigned D_FF_STAGES_DEF = 1;

  // True when the lane count and depth describe a buildable pipeline.
  function automatic bit d_ff_params_ok(input int unsigned width, input int unsigned stages);
    return (width >= 1) && (stages >= 1);
  endfunction

endpackage

// File: rtl/d_ff_bit.sv
// Single-bit flop with asynchronous active-high reset, reset value and enable.
module d_ff_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_r;

  // Capture d on enabled rising edges; reset forces RESET_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/d_ff_stage.sv
// WIDTH-lane, STAGES-deep flop pipeline used for retiming levels and forming edge pulses.
// Optional feature: define D_FF_EDGE_DETECT_EN to add the q_prev history and rise/fall strobes.
module d_ff_stage
  import d_ff_pkg::*;
#(
  parameter int unsigned      WIDTH     = D_FF_WIDTH_DEF,
  parameter int unsigned      STAGES    = D_FF_STAGES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef D_FF_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  // Reject illegal geometry while elaborating.
  if (!d_ff_params_ok(WIDTH, STAGES)) begin : g_param_err
    $error("d_ff_stage: WIDTH and STAGES must both be at least 1");
  end

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Flop grid: stage 0 samples d, each later stage samples its predecessor.
  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    for (genvar w = 0; w < int'(WIDTH); w++) begin : g_lane
      logic stage_d;

      if (s == 0) begin : g_in
        assign stage_d = d[w];
      end else begin : g_chain
        assign stage_d = stage_q[s-1][w];
      end

      d_ff_bit #(
        .RESET_VAL (RESET_VAL[w])
      ) u_bit (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (stage_d),
        .q   (stage_q[s][w])
      );
    end
  end

  assign q = stage_q[STAGES-1];

`ifdef D_FF_EDGE_DETECT_EN
  logic [WIDTH-1:0] q_prev;

  // History of q; shares the enable so a pending strobe holds while en is low.
  for (genvar w = 0; w < int'(WIDTH); w++) begin : g_prev
    d_ff_bit #(
      .RESET_VAL (RESET_VAL[w])
    ) u_prev (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (q[w]),
      .q   (q_prev[w])
    );
  end

  // Strobes come only from registered values; reset makes q == q_prev so both start at 0.
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;
`endif

endmodule

// File: tb/tb_d_ff_stage.sv
// Directed bench for d_ff_stage: a 4-lane single-stage instance and a 1-lane two-stage instance.
module tb_d_ff_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_a;
  logic       en_b;
  logic [3:0] d_a;
  logic [0:0] d_b;
  logic [3:0] q_a;
  logic [0:0] q_b;
`ifdef D_FF_EDGE_DETECT_EN
  logic [3:0] rise_a, fall_a;
  logic [0:0] rise_b, fall_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  d_ff_stage #(
    .WIDTH     (4),
    .STAGES    (1),
    .RESET_VAL (4'hA)
  ) dut_a (
    .clk  (clk),
    .rst  (rst),
    .en   (en_a),
    .d    (d_a),
    .q    (q_a)
`ifdef D_FF_EDGE_DETECT_EN
    ,
    .rise (rise_a),
    .fall (fall_a)
`endif
  );

  d_ff_stage #(
    .WIDTH     (1),
    .STAGES    (2),
    .RESET_VAL (1'b0)
  ) dut_b (
    .clk  (clk),
    .rst  (rst),
    .en   (en_b),
    .d    (d_b),
    .q    (q_b)
`ifdef D_FF_EDGE_DETECT_EN
    ,
    .rise (rise_b),
    .fall (fall_b)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Chain stimulus for dut_b, bit i is applied before edge i.
  logic [6:0] chain_d    = 7'b0000111;
  logic [6:0] chain_q    = 7'b0001110;
  logic [6:0] chain_rise = 7'b0000010;
  logic [6:0] chain_fall = 7'b0010000;
  logic [4:0][3:0] hold_d = {4'h9, 4'h0, 4'hF, 4'hC, 4'h5};

  initial begin
    en_a = 1'b1;
    en_b = 1'b1;
    d_a  = 4'hA;
    d_b  = 1'b0;
    rst  = 1'b1;
    #2;
    chk("por_q_a", q_a, 4'hA);
    chk("por_q_b", {3'b0, q_b}, 4'h0);
    step();
    step();
    rst = 1'b0;
    chk("rel_q_a", q_a, 4'hA);

    // Basic flop: lane 0 goes 0 -> 1.
    step();
    chk("base_hold_q", q_a, 4'hA);
`ifdef D_FF_EDGE_DETECT_EN
    chk("base_hold_rise", rise_a, 4'h0);
    chk("base_hold_fall", fall_a, 4'h0);
`endif
    d_a = 4'hB;
    step();
    chk("base_q", q_a, 4'hB);
`ifdef D_FF_EDGE_DETECT_EN
    chk("base_rise", rise_a, 4'h1);
    chk("base_fall", fall_a, 4'h0);
`endif
    step();
    chk("base_q2", q_a, 4'hB);
`ifdef D_FF_EDGE_DETECT_EN
    chk("base_rise2", rise_a, 4'h0);
`endif

    // Mid-cycle reset takes effect with no clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_q_a", q_a, 4'hA);
    chk("async_rst_q_b", {3'b0, q_b}, 4'h0);
`ifdef D_FF_EDGE_DETECT_EN
    chk("async_rst_rise", rise_a, 4'h0);
    chk("async_rst_fall", fall_a, 4'h0);
`endif
    #2;
    rst = 1'b0;
    d_a = 4'hA;

    // Two-stage chain: 3-cycle pulse emerges 2 edges later, 3 cycles wide.
    for (int i = 0; i < 7; i++) begin
      d_b = chain_d[i];
      step();
      chk($sformatf("chain_q%0d", i), {3'b0, q_b}, {3'b0, chain_q[i]});
`ifdef D_FF_EDGE_DETECT_EN
      chk($sformatf("chain_rise%0d", i), {3'b0, rise_b}, {3'b0, chain_rise[i]});
      chk($sformatf("chain_fall%0d", i), {3'b0, fall_b}, {3'b0, chain_fall[i]});
`endif
    end

    // Enable hold on dut_a: q and the pending strobe freeze.
    d_a = 4'h3;
    step();
    chk("hold_pre_q", q_a, 4'h3);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_a = hold_d[i];
      step();
      chk($sformatf("hold_q%0d", i), q_a, 4'h3);
`ifdef D_FF_EDGE_DETECT_EN
      chk($sformatf("hold_rise%0d", i), rise_a, 4'h1);
      chk($sformatf("hold_fall%0d", i), fall_a, 4'h8);
`endif
    end
    en_a = 1'b1;
    d_a  = 4'h6;
    step();
    chk("resume_q", q_a, 4'h6);
`ifdef D_FF_EDGE_DETECT_EN
    chk("resume_rise", rise_a, 4'h4);
    chk("resume_fall", fall_a, 4'h1);
`endif
    step();
    chk("resume_q2", q_a, 4'h6);
`ifdef D_FF_EDGE_DETECT_EN
    chk("resume_rise2", rise_a, 4'h0);
`endif

    // Reset while a one-cycle pulse is inside dut_b: it must never reach q.
    d_b = 1'b1;
    step();
    chk("rpulse_q0", {3'b0, q_b}, 4'h0);
    d_b = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rpulse_q1", {3'b0, q_b}, 4'h0);
    step();
    chk("rpulse_q2", {3'b0, q_b}, 4'h0);
    chk("rpulse_q_a", q_a, 4'hA);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rpulse_after_q%0d", i), {3'b0, q_b}, 4'h0);
`ifdef D_FF_EDGE_DETECT_EN
      chk($sformatf("rpulse_after_rise%0d", i), {3'b0, rise_b}, 4'h0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
